iddr_prbs_checker: RTL and testbench

//  Consumes the two IDDR sample outputs (rising-edge bit, falling-edge bit) each clk and checks

---
 rtl/iddr_prbs_checker_if.sv | 23 ++
 rtl/iddr_prbs_checker.sv | 158 +++++++++++++++
 tb/tb_iddr_prbs_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iddr_prbs_checker_if.sv
// IDDR PRBS checker bus: sample pair and control in, lock and error status out.
interface iddr_prbs_checker_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 in_valid;
  logic                 q_rise;
  logic                 q_fall;
  logic                 clear;
  logic                 locked;
  logic [1:0]           err_flags;
  logic [ERR_CNT_W-1:0] err_count;
  logic [7:0]           relock_count;

  modport master (
    output in_valid, q_rise, q_fall, clear,
    input  locked, err_flags, err_count, relock_count
  );

  modport slave (
    input  in_valid, q_rise, q_fall, clear,
    output locked, err_flags, err_count, relock_count
  );
endinterface

// File: rtl/iddr_prbs_checker.sv
// PRBS7 (x^7+x^6+1) checker for an IDDR sample pair per clock. Self-seeds from received data,
// qualifies lock over LOCK_GOOD clean pairs, counts bit errors and drops lock when too many
// errors land in one window.
module iddr_prbs_checker #(
  parameter int unsigned ERR_CNT_W   = 16,
  parameter int unsigned LOCK_GOOD   = 16,
  parameter int unsigned LOSS_WINDOW = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter bit          SWAP_EDGES  = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  iddr_prbs_checker_if.slave bus
);

  localparam int unsigned GoodW   = $clog2(LOCK_GOOD + 1);
  localparam int unsigned WinCntW = $clog2(LOSS_WINDOW);
  localparam int unsigned WinErrW = $clog2(2 * LOSS_WINDOW + 2);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e               state_q;
  logic [6:0]           hist_q;         // hist_q[0] is the newest bit
  logic [3:0]           seed_cnt_q;
  logic [GoodW-1:0]     good_q;
  logic [WinCntW-1:0]   win_cnt_q;
  logic [WinErrW-1:0]   win_err_q;
  logic                 locked_q;
  logic [1:0]           err_flags_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [7:0]           relock_count_q;

  logic                 bit_a;
  logic                 bit_b;
  logic                 pred_a;
  logic                 pred_b;
  logic [1:0]           mis;
  logic [1:0]           n_err;
  logic [6:0]           hist_seed;
  logic [6:0]           hist_pred;
  logic [ERR_CNT_W:0]   err_sum;
  logic [ERR_CNT_W-1:0] err_sat;
  logic [GoodW-1:0]     good_next;
  logic                 win_wrap;
  logic [WinErrW-1:0]   win_err_next;
  logic                 loss;

  // Pair ordering, PRBS predictions and the counter arithmetic used by the state machine.
  always_comb begin
    bit_a     = SWAP_EDGES ? bus.q_fall : bus.q_rise;
    bit_b     = SWAP_EDGES ? bus.q_rise : bus.q_fall;
    // b is one bit later than a, so its taps sit one position newer in the history.
    pred_a    = hist_q[6] ^ hist_q[5];
    pred_b    = hist_q[5] ^ hist_q[4];
    mis       = {bit_a ^ pred_a, bit_b ^ pred_b};
    n_err     = {1'b0, mis[1]} + {1'b0, mis[0]};
    hist_seed = {hist_q[4:0], bit_a, bit_b};
    // Once seeded the generator free-runs on its own predictions, so a flipped bit costs
    // exactly one error instead of corrupting the following predictions.
    hist_pred = {hist_q[4:0], pred_a, pred_b};
    err_sum   = {1'b0, err_count_q} + (ERR_CNT_W + 1)'(n_err);
    err_sat   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    good_next = good_q + GoodW'(1);
    win_wrap  = (win_cnt_q == WinCntW'(LOSS_WINDOW - 1));
    // A wrapping cycle opens the new window with its own errors.
    win_err_next = win_wrap ? WinErrW'(n_err) : win_err_q + WinErrW'(n_err);
    loss         = (win_err_next >= WinErrW'(LOSS_THRESH));
  end

  // Seed / verify / locked state machine with all status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StSeed;
      hist_q         <= '0;
      seed_cnt_q     <= '0;
      good_q         <= '0;
      win_cnt_q      <= '0;
      win_err_q      <= '0;
      locked_q       <= 1'b0;
      err_flags_q    <= '0;
      err_count_q    <= '0;
      relock_count_q <= '0;
    end else if (bus.clear) begin
      state_q        <= StSeed;
      seed_cnt_q     <= '0;
      good_q         <= '0;
      win_cnt_q      <= '0;
      win_err_q      <= '0;
      locked_q       <= 1'b0;
      err_flags_q    <= '0;
      err_count_q    <= '0;
      relock_count_q <= '0;
    end else if (!bus.in_valid) begin
      err_flags_q <= '0;
    end else begin
      unique case (state_q)
        StSeed: begin
          hist_q      <= hist_seed;
          err_flags_q <= '0;
          if (seed_cnt_q == 4'd6) begin
            seed_cnt_q <= '0;
            // All-zero is the LFSR lock-up state; keep seeding.
            if (hist_seed != 7'd0) begin
              state_q <= StVerify;
              good_q  <= '0;
            end
          end else begin
            seed_cnt_q <= seed_cnt_q + 4'd2;
          end
        end
        StVerify: begin
          hist_q      <= hist_pred;
          err_flags_q <= mis;
          if (mis != 2'b00) begin
            state_q    <= StSeed;
            seed_cnt_q <= '0;
            good_q     <= '0;
          end else if (good_next == GoodW'(LOCK_GOOD)) begin
            state_q   <= StLocked;
            locked_q  <= 1'b1;
            good_q    <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
          end else begin
            good_q <= good_next;
          end
        end
        StLocked: begin
          hist_q      <= hist_pred;
          err_flags_q <= mis;
          err_count_q <= err_sat;
          if (loss) begin
            state_q    <= StSeed;
            locked_q   <= 1'b0;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            if (relock_count_q != 8'hFF) begin
              relock_count_q <= relock_count_q + 8'd1;
            end
          end else begin
            win_cnt_q <= win_wrap ? '0 : win_cnt_q + WinCntW'(1);
            win_err_q <= win_err_next;
          end
        end
        default: begin
          state_q <= StSeed;
        end
      endcase
    end
  end

  assign bus.locked       = locked_q;
  assign bus.err_flags    = err_flags_q;
  assign bus.err_count    = err_count_q;
  assign bus.relock_count = relock_count_q;

endmodule

// File: tb/tb_iddr_prbs_checker.sv
// Scoreboard bench for iddr_prbs_checker: a queue-based PRBS7 reference model predicts each
// cycle's outputs; a monitor compares two DUTs (normal and swapped edge order) against it.
module tb_iddr_prbs_checker;

  localparam int unsigned ERR_CNT_W   = 16;
  localparam int unsigned LOCK_GOOD   = 16;
  localparam int unsigned LOSS_WINDOW = 64;
  localparam int unsigned LOSS_THRESH = 8;

  typedef struct packed {
    logic                 locked;
    logic [1:0]           flags;
    logic [ERR_CNT_W-1:0] errc;
    logic [7:0]           relock;
  } exp_t;

  logic clk;
  logic rst_n;

  iddr_prbs_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus0 ();
  iddr_prbs_checker_if #(.ERR_CNT_W(ERR_CNT_W)) bus1 ();

  iddr_prbs_checker #(
    .ERR_CNT_W  (ERR_CNT_W),
    .LOCK_GOOD  (LOCK_GOOD),
    .LOSS_WINDOW(LOSS_WINDOW),
    .LOSS_THRESH(LOSS_THRESH),
    .SWAP_EDGES (1'b0)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  iddr_prbs_checker #(
    .ERR_CNT_W  (ERR_CNT_W),
    .LOCK_GOOD  (LOCK_GOOD),
    .LOSS_WINDOW(LOSS_WINDOW),
    .LOSS_THRESH(LOSS_THRESH),
    .SWAP_EDGES (1'b1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 seeding, 1 verifying, 2 locked. m_hist holds the last 7 stream bits, oldest first.
  int   m_phase;
  bit   m_hist[$];
  int   m_pairs;
  int   m_good;
  int   m_wcnt;
  int   m_werr;
  int   m_errs;
  int   m_relocks;
  bit   m_locked;
  bit [1:0] m_flags;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
    m_phase = 0; m_pairs = 0; m_good = 0; m_wcnt = 0; m_werr = 0;
    m_errs = 0; m_relocks = 0; m_locked = 1'b0; m_flags = 2'b00;
  endfunction

  function automatic void shift_in(input bit x);
    bit old;
    m_hist.push_back(x);
    old = m_hist.pop_front();
  endfunction

  // Next PRBS7 bit from the last seven: s[n] = s[n-7] ^ s[n-6].
  function automatic bit model_pred();
    return m_hist[0] ^ m_hist[1];
  endfunction

  function automatic void model_step(input bit v, input bit a, input bit b, input bit clr);
    bit pa, pb, ea, eb, all_zero;
    int n;
    if (clr) begin
      m_errs = 0; m_relocks = 0; m_locked = 1'b0; m_phase = 0; m_pairs = 0;
      m_good = 0; m_wcnt = 0; m_werr = 0; m_flags = 2'b00;
    end else if (!v) begin
      m_flags = 2'b00;
    end else if (m_phase == 0) begin
      shift_in(a);
      shift_in(b);
      m_flags = 2'b00;
      m_pairs++;
      if (m_pairs == 4) begin
        m_pairs  = 0;
        all_zero = 1'b1;
        foreach (m_hist[i]) if (m_hist[i]) all_zero = 1'b0;
        if (!all_zero) begin
          m_phase = 1;
          m_good  = 0;
        end
      end
    end else begin
      pa = model_pred();
      shift_in(pa);
      pb = model_pred();
      shift_in(pb);
      ea = (a != pa);
      eb = (b != pb);
      n  = int'(ea) + int'(eb);
      m_flags = {ea, eb};
      if (m_phase == 1) begin
        if (n != 0) begin
          m_phase = 0; m_pairs = 0; m_good = 0;
        end else begin
          m_good++;
          if (m_good == LOCK_GOOD) begin
            m_phase = 2; m_locked = 1'b1; m_good = 0; m_wcnt = 0; m_werr = 0;
          end
        end
      end else begin
        m_errs = m_errs + n;
        if (m_errs > (2 ** ERR_CNT_W) - 1) m_errs = (2 ** ERR_CNT_W) - 1;
        if (m_wcnt == LOSS_WINDOW - 1) begin
          m_wcnt = 0;
          m_werr = n;
        end else begin
          m_wcnt++;
          m_werr += n;
        end
        if (m_werr >= LOSS_THRESH) begin
          m_phase = 0; m_locked = 1'b0; m_pairs = 0; m_wcnt = 0; m_werr = 0;
          if (m_relocks < 255) m_relocks++;
        end
      end
    end
  endfunction

  // ---------------- PRBS7 source, seed 7'h7F ----------------
  bit g_hist[$];

  function automatic bit gen_bit();
    bit n, old;
    n = g_hist[0] ^ g_hist[1];
    g_hist.push_back(n);
    old = g_hist.pop_front();
    return n;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit v, input bit a, input bit b, input bit clr);
    exp_t e;
    @(negedge clk);
    bus0.in_valid = v; bus0.clear = clr; bus0.q_rise = a; bus0.q_fall = b;
    bus1.in_valid = v; bus1.clear = clr; bus1.q_rise = b; bus1.q_fall = a;
    model_step(v, a, b, clr);
    e.locked = m_locked;
    e.flags  = m_flags;
    e.errc   = ERR_CNT_W'(m_errs);
    e.relock = 8'(m_relocks);
    exp_q.push_back(e);
  endtask

  task automatic clean_step();
    bit a, b;
    a = gen_bit();
    b = gen_bit();
    step(1'b1, a, b, 1'b0);
  endtask

  task automatic clean_steps(input int n);
    for (int i = 0; i < n; i++) clean_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_outs(input string tag, input int lk, input int fl, input int ec,
                          input int rc);
    chk({tag, "_locked"}, int'(bus0.locked), lk);
    chk({tag, "_flags"}, int'(bus0.err_flags), fl);
    chk({tag, "_errc"}, int'(bus0.err_count), ec);
    chk({tag, "_relock"}, int'(bus0.relock_count), rc);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sb0_locked", int'(bus0.locked), int'(mon_e.locked));
      chk("sb0_flags", int'(bus0.err_flags), int'(mon_e.flags));
      chk("sb0_errc", int'(bus0.err_count), int'(mon_e.errc));
      chk("sb0_relock", int'(bus0.relock_count), int'(mon_e.relock));
      chk("sb1_locked", int'(bus1.locked), int'(mon_e.locked));
      chk("sb1_flags", int'(bus1.err_flags), int'(mon_e.flags));
      chk("sb1_errc", int'(bus1.err_count), int'(mon_e.errc));
      chk("sb1_relock", int'(bus1.relock_count), int'(mon_e.relock));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit a, b;
    int r;
    for (int i = 0; i < 7; i++) g_hist.push_back(1'b1);
    model_reset();
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.clear = 1'b0; bus0.q_rise = 1'b0; bus0.q_fall = 1'b0;
    bus1.in_valid = 1'b0; bus1.clear = 1'b0; bus1.q_rise = 1'b0; bus1.q_fall = 1'b0;
    #2;
    chk_outs("reset", 0, 0, 0, 0);
    #10;
    rst_n = 1'b1;

    // Clean stream: lock on exactly the 20th valid pair, then stay error-free.
    clean_steps(19);
    after_edge();
    chk("t1_not_locked_19", int'(bus0.locked), 0);
    clean_step();
    after_edge();
    chk("t1_locked_20", int'(bus0.locked), 1);
    clean_steps(1000);
    after_edge();
    chk_outs("t1_end", 1, 0, 0, 0);

    // One flipped earlier bit: a single flagged error, lock kept.
    a = gen_bit(); b = gen_bit();
    step(1'b1, ~a, b, 1'b0);
    after_edge();
    chk_outs("t2_err", 1, 2, 1, 0);
    clean_step();
    after_edge();
    chk("t2_flags_clear", int'(bus0.err_flags), 0);

    // Four fully inverted pairs: loss of lock on the fourth, relock 20 pairs later.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    clean_steps(20);
    for (int i = 0; i < 4; i++) begin
      a = gen_bit(); b = gen_bit();
      step(1'b1, ~a, ~b, 1'b0);
    end
    after_edge();
    chk_outs("t3_loss", 0, 3, 8, 1);
    clean_steps(19);
    after_edge();
    chk("t3_not_relocked_19", int'(bus0.locked), 0);
    clean_step();
    after_edge();
    chk("t3_relocked_20", int'(bus0.locked), 1);

    // Constant zero: never seeds.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk_outs("t4_zero", 0, 0, 0, 0);

    // in_valid toggling: lock on the 20th valid pair, 40th cycle.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 1) clean_step();
      else step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if (i == 38) begin
        after_edge();
        chk("t5_not_locked_39", int'(bus0.locked), 0);
      end
    end
    after_edge();
    chk_outs("t5_locked_40", 1, 0, 0, 0);

    // Async reset mid-lock, then clear with err_count=5.
    clean_steps(2);
    @(negedge clk);
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_outs("t6_async_rst", 0, 0, 0, 0);
    chk("t6_async_rst_dut1", int'(bus1.locked), 0);
    model_reset();
    #1 rst_n = 1'b1;
    clean_steps(20);
    after_edge();
    chk("t6_relock_after_rst", int'(bus0.locked), 1);
    for (int i = 0; i < 5; i++) begin
      a = gen_bit(); b = gen_bit();
      step(1'b1, ~a, b, 1'b0);
      clean_step();
    end
    after_edge();
    chk_outs("t6_five_errs", 1, 0, 5, 0);
    a = gen_bit(); b = gen_bit();
    step(1'b1, a, b, 1'b1);
    after_edge();
    chk_outs("t6_clear", 0, 0, 0, 0);
    clean_steps(19);
    after_edge();
    chk("t6_not_locked_19", int'(bus0.locked), 0);
    clean_step();
    after_edge();
    chk("t6_locked_20", int'(bus0.locked), 1);

    // Randomised traffic: gaps, sparse bit errors, occasional clears.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        a = gen_bit(); b = gen_bit();
        step(1'($urandom_range(0, 1)), a, b, 1'b1);
      end else if (r < 250) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        a = gen_bit(); b = gen_bit();
        if ($urandom_range(0, 99) < 3) a = ~a;
        if ($urandom_range(0, 99) < 3) b = ~b;
        step(1'b1, a, b, 1'b0);
      end
    end

    @(posedge clk);
    #3;
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
